// File: rtl/dpram_stream_reader_if.sv
// Bus, RAM read-port and output-stream signals of dpram_stream_reader.
// The slave modport is the reader's view; master is the environment's view.
interface dpram_stream_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cs;
    logic              rd;
    logic              wr;
    logic [15:0]       addr;
    logic [15:0]       d_in;
    logic [15:0]       d_out;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  cs, rd, wr, addr, d_in, ram_data, m_ready,
        output d_out, ram_re, ram_addr, m_valid, m_data, m_last
    );

    modport master (
        output cs, rd, wr, addr, d_in, ram_data, m_ready,
        input  d_out, ram_re, ram_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/dpram_stream_reader.sv
// Streams LEN words starting at BASE out of the dual-port RAM read port,
// one word per READ/LOAD/SEND round, under CPU control via a small register bus.
module dpram_stream_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    dpram_stream_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SEND
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_BASE   = 3'd1;
    localparam logic [2:0] A_LEN    = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_COUNT  = 3'd4;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_len;
    logic [15:0]       r_count;
    logic [15:0]       r_remaining;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_done;
    logic              r_aborted;
    logic [15:0]       r_d_out;
    logic              r_ram_re;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;

    logic [2:0]        w_sel;
    logic              w_wr;
    logic              w_rd;
    logic              w_busy;
    logic              w_start;
    logic              w_abort;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [15:0]       w_regs [8];
    logic              w_unused_addr;

    assign w_sel         = bus.addr[2:0];
    assign w_wr          = bus.cs && bus.wr;
    assign w_rd          = bus.cs && bus.rd;
    assign w_busy        = (r_state != ST_IDLE);
    assign w_start       = w_wr && (w_sel == A_CTRL) && bus.d_in[0];
    assign w_abort       = w_wr && (w_sel == A_CTRL) && bus.d_in[1];
    assign w_ptr_inc     = r_ptr + ADDR_W'(1);
    assign w_unused_addr = ^bus.addr[15:3];

    // Read-back table; CTRL is write-only and the upper three slots are holes.
    assign w_regs[A_CTRL]   = 16'd0;
    assign w_regs[A_BASE]   = 16'(r_base);
    assign w_regs[A_LEN]    = r_len;
    assign w_regs[A_STATUS] = {13'd0, r_aborted, r_done, w_busy};
    assign w_regs[A_COUNT]  = r_count;
    generate
        for (genvar gi = 5; gi < 8; gi++) begin : g_hole
            assign w_regs[gi] = 16'd0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_out <= 16'd0;
        end else if (w_rd) begin
            r_d_out <= w_regs[w_sel];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_len       <= 16'd0;
            r_count     <= 16'd0;
            r_remaining <= 16'd0;
            r_ptr       <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_addr  <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
        end else begin
            if (w_wr && (w_sel == A_BASE) && !w_busy) r_base <= ADDR_W'(bus.d_in);
            if (w_wr && (w_sel == A_LEN) && !w_busy)  r_len  <= bus.d_in;

            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_abort) begin
                        r_count   <= 16'd0;
                        r_aborted <= 1'b0;
                        if (r_len == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_done      <= 1'b0;
                            r_ptr       <= r_base;
                            r_remaining <= r_len;
                            r_ram_re    <= 1'b1;
                            r_ram_addr  <= r_base;
                            r_state     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_ram_re <= 1'b0;
                    r_state  <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_m_data  <= bus.ram_data;
                    r_m_valid <= 1'b1;
                    r_m_last  <= (r_remaining == 16'd1);
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.m_ready) begin
                        r_m_valid   <= 1'b0;
                        r_m_last    <= 1'b0;
                        r_count     <= r_count + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                        r_ptr       <= w_ptr_inc;
                        if (r_m_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ram_re   <= 1'b1;
                            r_ram_addr <= w_ptr_inc;
                            r_state    <= ST_READ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Abort overrides whatever the state logic scheduled this edge,
            // including a handshake landing on the same edge.
            if (w_abort && w_busy) begin
                r_state   <= ST_IDLE;
                r_ram_re  <= 1'b0;
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                r_count   <= r_count;
                r_done    <= r_done;
                r_aborted <= 1'b1;
            end
        end
    end

    assign bus.d_out    = r_d_out;
    assign bus.ram_re   = r_ram_re;
    assign bus.ram_addr = r_ram_addr;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_data   = r_m_data;
    assign bus.m_last   = r_m_last;
endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Drains a block of words from the read port of the CPU-written dual-port RAM and presents them, one at a time, on a valid/ready output stream.
- Typical consumers are a UART TX, an SPI shifter or a display scanner.
- The CPU programs the base address and length through the same cs/rd/wr/addr peripheral bus the RAM peripheral uses, then starts a transfer.
- The CPU polls a status register for busy/done.

Parameters:
- ADDR_W, 16, width of the RAM read address and of the BASE register.
- DATA_W, 16, width of RAM words and of the stream data.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  peripheral select.
- rd  in  1  bus read strobe, qualified by cs.
- wr  in  1  bus write strobe, qualified by cs.
- addr  in  16  bus address; only addr[2:0] decoded.
- d_in  in  16  bus write data.
- d_out  out  16  bus read data.
- ram_re  out  1  RAM read-port enable; drives both en_b and re_b.
- ram_addr  out  ADDR_W  RAM read address.
- ram_data  in  DATA_W  RAM read data; valid exactly 1 cycle after ram_re is high.
- m_valid  out  1  stream word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  stream word.
- m_last  out  1  high with the final word of the transfer.

Behaviour:
- Register map (addr[2:0]):
  - 0 CTRL, write-only: bit0 START, bit1 ABORT.
  - 1 BASE, R/W.
  - 2 LEN, R/W, word count.
  - 3 STATUS, read-only: bit0 BUSY, bit1 DONE, bit2 ABORTED.
  - 4 COUNT, read-only: words accepted by the consumer in the current or last transfer.
  - 5-7: reads return 0, writes are ignored.
- Bus write: takes effect on the edge where cs=1 and wr=1.
- Bus read: cs=1 and rd=1 registers the selected value into d_out. Latency is 1 cycle, and d_out holds until the next read. Reads of registers wider than 16 bits return the low 16 bits.
- Writes to BASE or LEN while BUSY are ignored.
- Reset values: d_out=0, BASE=0, LEN=0, COUNT=0, STATUS=0, ram_re=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, FSM=IDLE.
- FSM states: IDLE, READ, LOAD, SEND.
- IDLE:
  - START with LEN=0: set DONE, clear ABORTED, COUNT=0, stay in IDLE. No ram_re and no stream word are produced.
  - START with LEN>0: ptr=BASE, remaining=LEN, COUNT=0, clear DONE and ABORTED, BUSY=1, go to READ.
- READ: ram_re=1 and ram_addr=ptr for exactly one cycle; go to LOAD.
- LOAD: m_data<=ram_data, m_valid<=1, m_last<=(remaining==1); go to SEND. m_valid is therefore high 2 cycles after the READ cycle.
- SEND: m_valid and m_data are held stable until m_ready=1. On the handshake edge:
  - m_valid<=0, COUNT+=1, remaining-=1, ptr+=1.
  - If m_last, set DONE, clear BUSY, go to IDLE; otherwise go to READ.
- Throughput: at most 1 word per 3 cycles. This is acceptable; prefetch is out of scope.
- ptr wraps modulo 2^ADDR_W: BASE=0xFFFF with LEN=2 reads 0xFFFF then 0x0000.
- ram_re is 0 in every state except READ. ram_addr holds its last value when idle.
- START while BUSY is ignored.
- ABORT in any non-IDLE state:
  - On the next edge: go to IDLE, m_valid=0, m_last=0, BUSY=0, ABORTED=1, DONE unchanged (0). COUNT keeps the words already accepted.
  - A handshake on the same edge as ABORT is not counted; ABORT wins.
- ABORT in IDLE has no effect.
- START and ABORT written together: ABORT wins, and no transfer starts.
- STATUS reads do not clear flags. The next START clears DONE and ABORTED.
- Asserting reset mid-transfer immediately returns every register and output to its reset value. No further ram_re and no partial stream word are produced.

Test Plan:
- Write BASE=0x0010, LEN=3, START, with m_ready tied 1 and RAM[0x10..0x12]=0xA1,0xB2,0xC3 -> stream 0xA1,0xB2,0xC3, m_last only on 0xC3, ram_re pulsed exactly 3 times. STATUS then reads 0x2 and COUNT reads 3.
- Same transfer with m_ready low for 5 cycles on word 2 -> m_data=0xB2 and m_valid held stable for those 5 cycles, no extra ram_re, final COUNT=3.
- LEN=0, START -> no ram_re and no m_valid; STATUS=0x2 one cycle after the write.
- BASE=0xFFFF, LEN=2 -> ram_addr sequence 0xFFFF, 0x0000.
- LEN=4; ABORT after the first word is accepted, while word 2 is in SEND -> m_valid drops the next cycle, STATUS=0x4, COUNT=1. A subsequent START runs all 4 words cleanly.
- Reset asserted while in SEND -> m_valid=0, STATUS=0 and all registers 0 immediately. Writing BASE/LEN while BUSY leaves them unchanged, checked by readback.
